// File: rtl/seg_display_arbiter_pkg.sv
// Shared constants and helpers for the seven-segment display arbiter.
// Holds the blank/off encodings, the anode table for the four digit
// slots, the guard-slot index, the arbitration state type and small
// helpers for slot sequencing and digit extraction from a 4-glyph word.
package seg_display_arbiter_pkg;

  localparam int          GLYPH_W     = 28;
  localparam int          DIGIT_W     = 7;
  localparam int          SLOT_W      = 3;

  localparam logic [6:0]  SEG_BLANK   = 7'b1111111;
  localparam logic [3:0]  AN_OFF      = 4'b1111;
  localparam logic [2:0]  SLOT_GUARD  = 3'd4;
  localparam logic [27:0] GLYPH_BLANK = {GLYPH_W{1'b1}};

  // Active-low anode enable for digit slots 0..3 (digit0 is leftmost).
  localparam logic [3:0]  AN_TABLE [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Slot sequence 0,1,2,3,4,0 where 4 is the blank guard slot.
  function automatic logic [2:0] next_slot(input logic [2:0] slot);
    return (slot >= SLOT_GUARD) ? 3'd0 : slot + 3'd1;
  endfunction

  // digit0 sits in the top 7 bits of the glyph word, digit3 in the bottom 7.
  function automatic logic [6:0] glyph_digit(input logic [27:0] g, input logic [1:0] d);
    logic [6:0] r;
    case (d)
      2'd0:    r = g[27:21];
      2'd1:    r = g[20:14];
      2'd2:    r = g[13:7];
      default: r = g[6:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_scan.sv
// seg_scan_timer: scan prescaler and slot counter.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   tick          - one-cycle strobe on the last prescaler count of a slot
//   slot          - current scan slot 0..4 (4 = blank guard slot)
//   frame_tick    - tick that ends the guard slot, i.e. the frame boundary
module seg_scan_timer
  import seg_display_arbiter_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              tick,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_tick
);

  localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              tick_w;

  always_comb begin
    tick_w = (cnt_q == CNT_LAST);
    cnt_d  = tick_w ? '0 : cnt_q + 1'b1;
    slot_d = tick_w ? next_slot(slot_q) : slot_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  assign tick       = tick_w;
  assign slot       = slot_q;
  assign frame_tick = tick_w && (slot_q == SLOT_GUARD);

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: time-shares a 4-digit seven-segment display
// between NREQ requesters. Digits are scanned in a 5-slot frame (four
// digits plus a blank guard slot); ownership is arbitrated round-robin
// only at frame boundaries with a minimum hold of MIN_HOLD frames.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   req           - level-sensitive display request per requester
//   glyphs        - 4 active-low glyphs per requester, 28 bits each
//   grant         - one-hot current owner, zero when idle
//   frame_done    - one-cycle pulse at each frame boundary
//   an, seg       - active-low anode enables and segment pattern
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int SCAN_DIV = 100000,
  parameter int MIN_HOLD = 250
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*GLYPH_W-1:0] glyphs,
  output logic [NREQ-1:0]         grant,
  output logic                    frame_done,
  output logic [3:0]              an,
  output logic [6:0]              seg
);

  localparam int               IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int               HOLD_W   = $clog2(MIN_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  logic              tick;
  logic [SLOT_W-1:0] slot;
  logic              frame_tick;

  seg_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .slot       (slot),
    .frame_tick (frame_tick)
  );

  arb_state_e          state_q,      state_d;
  logic [IDX_W-1:0]    owner_q,      owner_d;
  logic [HOLD_W-1:0]   hold_q,       hold_d;
  logic [IDX_W-1:0]    rr_q,         rr_d;
  logic [NREQ-1:0]     grant_q,      grant_d;
  logic [GLYPH_W-1:0]  latch_q,      latch_d;
  logic [3:0]          an_q,         an_d;
  logic [6:0]          seg_q,        seg_d;
  logic                frame_done_q, frame_done_d;

  logic [IDX_W:0]      pick;
  logic                take;
  logic [SLOT_W-1:0]   slot_nx;
  logic [NREQ-1:0]     req_sh;

  // Returns {found, index} of the first set bit of mask at or after start,
  // wrapping modulo NREQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] mask,
                                             input logic [IDX_W-1:0] start);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [NREQ-1:0]  sh;
    int               c;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      c  = (int'(start) + i) % NREQ;
      sh = mask >> c;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = IDX_W'(c);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] k);
    return IDX_W'((int'(k) + 1) % NREQ);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] k);
    return NREQ'(1) << k;
  endfunction

  function automatic logic [GLYPH_W-1:0] owner_glyph(input logic [NREQ*GLYPH_W-1:0] g,
                                                     input logic [IDX_W-1:0] k);
    logic [NREQ*GLYPH_W-1:0] sh;
    sh = g >> (GLYPH_W * int'(k));
    return sh[GLYPH_W-1:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    hold_d       = hold_q;
    rr_d         = rr_q;
    latch_d      = latch_q;
    an_d         = an_q;
    seg_d        = seg_q;
    pick         = '0;
    take         = 1'b0;
    req_sh       = req >> owner_q;
    slot_nx      = next_slot(slot);
    frame_done_d = frame_tick;

    if (frame_tick) begin
      case (state_q)
        ARB_IDLE: begin
          pick = rr_pick(req, rr_q);
          take = pick[IDX_W];
        end
        ARB_OWNED: begin
          if (!req_sh[0]) begin
            // Owner released: hand over to the next pending requester, if any.
            pick = rr_pick(req, idx_inc(owner_q));
            take = pick[IDX_W];
            if (!take) begin
              state_d = ARB_IDLE;
              hold_d  = '0;
            end
          end else if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end else begin
            // Hold satisfied: rotate only if someone else is waiting,
            // otherwise keep the owner with hold saturated.
            pick = rr_pick(req & ~onehot(owner_q), idx_inc(owner_q));
            take = pick[IDX_W];
          end
        end
      endcase

      if (take) begin
        state_d = ARB_OWNED;
        owner_d = pick[IDX_W-1:0];
        hold_d  = HOLD_W'(1);
        rr_d    = idx_inc(pick[IDX_W-1:0]);
      end

      // The latch is the only place glyphs are sampled, so a frame never tears.
      latch_d = (state_d == ARB_OWNED) ? owner_glyph(glyphs, owner_d) : GLYPH_BLANK;
    end

    // Outputs are loaded for the slot being entered; at a boundary this uses
    // the freshly loaded latch so digit0 of the new frame is correct. An idle
    // display keeps every anode off.
    if (tick) begin
      if (slot_nx == SLOT_GUARD || state_d != ARB_OWNED) begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end else begin
        an_d  = AN_TABLE[slot_nx[1:0]];
        seg_d = glyph_digit(latch_d, slot_nx[1:0]);
      end
    end

    grant_d = (state_d == ARB_OWNED) ? onehot(owner_d) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      hold_q       <= '0;
      rr_q         <= '0;
      grant_q      <= '0;
      latch_q      <= GLYPH_BLANK;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      hold_q       <= hold_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      latch_q      <= latch_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign grant      = grant_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NREQ=2, SCAN_DIV=4, MIN_HOLD=2.
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [55:0] glyphs;
  logic [1:0]  grant;
  logic        frame_done;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int n;

  localparam logic [27:0] G0 = {7'b1111000, 7'b0000010, 7'b0000000, 7'b0010000};
  localparam logic [27:0] G1 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] G2 = {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};

  logic [3:0] an_tab [5] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1111};

  seg_display_arbiter #(
    .NREQ     (2),
    .SCAN_DIV (4),
    .MIN_HOLD (2)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .req        (req),
    .glyphs     (glyphs),
    .grant      (grant),
    .frame_done (frame_done),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (frame_done !== 1'b1 && cnt < 60);
    chk("fd_timeout", {31'd0, frame_done}, 32'd1);
  endtask

  // Check cycles c0..c1-1 of a frame (cycle 0 = the frame_done cycle).
  task automatic scan_check(input string tag, input logic [27:0] g,
                            input int c0, input int c1, input logic [1:0] gexp);
    logic [6:0] exp_seg;
    logic [27:0] sh;
    int s;
    for (int c = c0; c < c1; c++) begin
      s = c / 4;
      sh = g >> (7 * (3 - s));
      exp_seg = (s == 4) ? 7'h7F : sh[6:0];
      chk({tag, "_an"},    {28'd0, an},    {28'd0, an_tab[s]});
      chk({tag, "_seg"},   {25'd0, seg},   {25'd0, exp_seg});
      chk({tag, "_grant"}, {30'd0, grant}, {30'd0, gexp});
      step(1);
    end
    if (c1 == 20) chk({tag, "_fd"}, {31'd0, frame_done}, 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    req    = 2'b00;
    glyphs = {G1, G0};
    step(3);
    chk("rst_an",    {28'd0, an},         32'hF);
    chk("rst_seg",   {25'd0, seg},        32'h7F);
    chk("rst_grant", {30'd0, grant},      32'd0);
    chk("rst_fd",    {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // 1: idle frames stay blank, frame_done every 20 cycles
    wait_fd(n);
    chk("t1_first_period", n, 32'd20);
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 20; c++) begin
        chk("t1_an",    {28'd0, an},    32'hF);
        chk("t1_seg",   {25'd0, seg},   32'h7F);
        chk("t1_grant", {30'd0, grant}, 32'd0);
        if (c == 10) chk("t1_fd_low", {31'd0, frame_done}, 32'd0);
        step(1);
      end
      chk("t1_fd", {31'd0, frame_done}, 32'd1);
    end

    // 2: single requester gets the display from the next boundary
    req = 2'b01;
    wait_fd(n);
    chk("t2_period", n, 32'd20);
    scan_check("t2", G0, 0, 20, 2'b01);

    // 3: simultaneous requests from idle alternate every MIN_HOLD frames
    rst = 1'b1;
    req = 2'b11;
    step(2);
    rst = 1'b0;
    wait_fd(n);
    for (int f = 0; f < 6; f++) begin
      if (((f / 2) % 2) == 0) scan_check("t3_own0", G0, 0, 20, 2'b01);
      else                    scan_check("t3_own1", G1, 0, 20, 2'b10);
    end

    // 4: owner 0 releases mid-slot1; frame completes with its glyphs
    rst = 1'b1;
    req = 2'b11;
    step(2);
    rst = 1'b0;
    wait_fd(n);
    scan_check("t4_pre", G0, 0, 6, 2'b01);
    req = 2'b10;
    scan_check("t4_tail", G0, 6, 20, 2'b01);
    scan_check("t4_new", G1, 0, 20, 2'b10);

    // 5: owner glyph change mid-frame appears only from the next frame
    rst = 1'b1;
    req = 2'b01;
    glyphs = {G1, G0};
    step(2);
    rst = 1'b0;
    wait_fd(n);
    scan_check("t5_old", G0, 0, 10, 2'b01);
    glyphs[27:0] = G2;
    scan_check("t5_tail", G0, 10, 20, 2'b01);
    scan_check("t5_new", G2, 0, 20, 2'b01);

    // 6: reset in slot 2 while owned blanks at once and restarts the scan
    step(9);
    rst = 1'b1;
    step(1);
    chk("t6_an",    {28'd0, an},         32'hF);
    chk("t6_seg",   {25'd0, seg},        32'h7F);
    chk("t6_grant", {30'd0, grant},      32'd0);
    chk("t6_fd",    {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    wait_fd(n);
    chk("t6_period", n, 32'd20);
    chk("t6_regrant", {30'd0, grant}, 32'd1);
    scan_check("t6_scan", G2, 0, 20, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
